// File: rtl/axi_intr_pkg.sv
// rtl/axi_intr_pkg.sv - register offsets, response type and limits for axi_intr_ctrl
package axi_intr_pkg;

  localparam int unsigned MAX_INTR = 32;

  localparam logic [7:0] REG_GIE = 8'h00;
  localparam logic [7:0] REG_IER = 8'h04;
  localparam logic [7:0] REG_ISR = 8'h08;
  localparam logic [7:0] REG_IAR = 8'h0C;
  localparam logic [7:0] REG_IPR = 8'h10;
  localparam logic [7:0] REG_IMR = 8'h14;

  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi_intr_src.sv
// rtl/axi_intr_src.sv - one interrupt source: edge/level detect, ISR bit, pending output
// Define AXI_INTR_SYNC_EN to insert a 2-flop synchroniser ahead of edge detect.
module axi_intr_src
  import axi_intr_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic intr_in,
  input  logic edge_mode,
  input  logic ack,
  input  logic enable,
  output logic isr,
  output logic pend
);

  logic src;
  logic set;
  logic intr_d_q, intr_d_d;
  logic isr_q, isr_d;

`ifdef AXI_INTR_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = intr_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign src = sync2_q;
`else
  assign src = intr_in;
`endif

  // A set in the same cycle as an ack wins so the new event is never dropped.
  always_comb begin
    intr_d_d = src;
    set      = edge_mode ? (src & ~intr_d_q) : src;
    isr_d    = set | (isr_q & ~ack);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      intr_d_q <= 1'b0;
      isr_q    <= 1'b0;
    end else begin
      intr_d_q <= intr_d_d;
      isr_q    <= isr_d;
    end
  end

  assign isr  = isr_q;
  assign pend = isr_q & enable;

endmodule

// File: rtl/axi_intr_ctrl.sv
// rtl/axi_intr_ctrl.sv - AXI4-Lite interrupt controller aggregating NUM_INTR sources into irq
// Optional AXI_INTR_SYNC_EN adds input synchronisers inside each source cell.
module axi_intr_ctrl
  import axi_intr_pkg::*;
#(
  parameter int unsigned NUM_INTR           = 1,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter bit          IRQ_ACTIVE_HIGH    = 1'b1,
  parameter logic [31:0] RESET_MODE         = 32'h0
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [NUM_INTR-1:0]             intr,
  output logic                            irq,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int unsigned AW   = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned DW   = C_S_AXI_DATA_WIDTH;
  localparam int unsigned NSRC = (NUM_INTR > MAX_INTR) ? MAX_INTR : NUM_INTR;

  localparam logic [AW-1:0] A_GIE = AW'(REG_GIE);
  localparam logic [AW-1:0] A_IER = AW'(REG_IER);
  localparam logic [AW-1:0] A_ISR = AW'(REG_ISR);
  localparam logic [AW-1:0] A_IAR = AW'(REG_IAR);
  localparam logic [AW-1:0] A_IPR = AW'(REG_IPR);
  localparam logic [AW-1:0] A_IMR = AW'(REG_IMR);

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_RESP} rstate_e;

  wstate_e         wstate_q;
  rstate_e         rstate_q;
  logic            awready_q, bvalid_q, arready_q, rvalid_q;
  logic [DW-1:0]   rdata_q;
  logic [DW-1:0]   rmux;
  logic [DW-1:0]   wmask, wbits;
  logic            wr_en;

  logic            gie_q, gie_d;
  logic [NSRC-1:0] ier_q, ier_d;
  logic [NSRC-1:0] imr_q, imr_d;
  logic [NSRC-1:0] ack;
  logic [NSRC-1:0] isr, pend;
  logic            irq_q, irq_d;

  // Ready pulses for one cycle; the register write lands on the edge that ends it.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      case (wstate_q)
        W_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) begin
          awready_q <= 1'b1;
          wstate_q  <= W_ACK;
        end
        W_ACK: begin
          awready_q <= 1'b0;
          bvalid_q  <= 1'b1;
          wstate_q  <= W_RESP;
        end
        W_RESP: if (S_AXI_BREADY) begin
          bvalid_q <= 1'b0;
          wstate_q <= W_IDLE;
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (rstate_q)
        R_IDLE: if (S_AXI_ARVALID) begin
          arready_q <= 1'b1;
          rstate_q  <= R_ACK;
        end
        R_ACK: begin
          arready_q <= 1'b0;
          rvalid_q  <= 1'b1;
          rdata_q   <= rmux;
          rstate_q  <= R_RESP;
        end
        R_RESP: if (S_AXI_RREADY) begin
          rvalid_q <= 1'b0;
          rstate_q <= R_IDLE;
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign wr_en = (wstate_q == W_ACK);

  always_comb begin
    wmask = '0;
    for (int b = 0; b < DW / 8; b++) wmask[8*b +: 8] = {8{S_AXI_WSTRB[b]}};
    wbits = S_AXI_WDATA & wmask;
    gie_d = gie_q;
    ier_d = ier_q;
    imr_d = imr_q;
    ack   = '0;
    if (wr_en) begin
      case (S_AXI_AWADDR)
        A_GIE:   if (S_AXI_WSTRB[0]) gie_d = S_AXI_WDATA[0];
        A_IER:   ier_d = (ier_q & ~wmask[NSRC-1:0]) | wbits[NSRC-1:0];
        A_IAR:   ack   = wbits[NSRC-1:0];
        A_IMR:   imr_d = (imr_q & ~wmask[NSRC-1:0]) | wbits[NSRC-1:0];
        default: ;
      endcase
    end
    irq_d = gie_q & (|pend);
  end

  always_comb begin
    rmux = '0;
    case (S_AXI_ARADDR)
      A_GIE:   rmux = DW'(gie_q);
      A_IER:   rmux = DW'(ier_q);
      A_ISR:   rmux = DW'(isr);
      A_IPR:   rmux = DW'(pend);
      A_IMR:   rmux = DW'(imr_q);
      default: rmux = '0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      gie_q <= 1'b0;
      ier_q <= '0;
      imr_q <= RESET_MODE[NSRC-1:0];
      irq_q <= 1'b0;
    end else begin
      gie_q <= gie_d;
      ier_q <= ier_d;
      imr_q <= imr_d;
      irq_q <= irq_d;
    end
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    axi_intr_src u_src (
      .clk       (ACLK),
      .rst       (ARESET),
      .intr_in   (intr[i]),
      .edge_mode (imr_q[i]),
      .ack       (ack[i]),
      .enable    (ier_q[i]),
      .isr       (isr[i]),
      .pend      (pend[i])
    );
  end

  assign irq           = IRQ_ACTIVE_HIGH ? irq_q : ~irq_q;
  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, wmask, wbits};

endmodule

// File: tb/tb_axi_intr_ctrl.sv
// tb/tb_axi_intr_ctrl.sv - self-checking bench for axi_intr_ctrl (4 sources plus an active-low 1-source instance)
`timescale 1ns/1ps
module tb_axi_intr_ctrl;

  localparam logic [4:0] A_GIE = 5'h00, A_IER = 5'h04, A_ISR = 5'h08;
  localparam logic [4:0] A_IAR = 5'h0C, A_IPR = 5'h10, A_IMR = 5'h14;
  localparam int TMO = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  intr;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  wire         irq, awready, wready, bvalid, arready, rvalid;
  wire  [1:0]  bresp, rresp;
  wire  [31:0] rdata;
  wire         irq_n, awready2, wready2, bvalid2, arready2, rvalid2;
  wire  [1:0]  bresp2, rresp2;
  wire  [31:0] rdata2;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  axi_intr_ctrl #(.NUM_INTR(4), .IRQ_ACTIVE_HIGH(1'b1), .RESET_MODE(32'h0)) dut (
    .ACLK(clk), .ARESET(rst), .intr(intr), .irq(irq),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  axi_intr_ctrl #(.NUM_INTR(1), .IRQ_ACTIVE_HIGH(1'b0), .RESET_MODE(32'h0)) dut_n (
    .ACLK(clk), .ARESET(rst), .intr(intr[0]), .irq(irq_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready2),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready2),
    .S_AXI_BRESP(bresp2), .S_AXI_BVALID(bvalid2), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready2),
    .S_AXI_RDATA(rdata2), .S_AXI_RRESP(rresp2), .S_AXI_RVALID(rvalid2), .S_AXI_RREADY(rready)
  );

  wire unused_dut2 = ^{awready2, wready2, bvalid2, arready2, rvalid2, bresp2, rresp2, rdata2};

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int bdelay, input logic [3:0] hs_intr,
                           output logic irq_at_b, output logic held, output logic [1:0] resp);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < TMO);
    if (!awready) begin n_cmp++; n_err++; $display("FAIL write_aw_timeout addr=%h", a); end
    intr = intr | hs_intr;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    irq_at_b = irq;
    held = 1'b1;
    for (int k = 0; k < bdelay; k++) begin
      if (!bvalid) held = 1'b0;
      @(negedge clk);
    end
    if (!bvalid) begin n_cmp++; n_err++; $display("FAIL write_b_timeout addr=%h", a); end
    resp = bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, input int rdelay,
                          output logic [31:0] d, output logic [1:0] resp, output logic stable);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < TMO);
    if (!arready) begin n_cmp++; n_err++; $display("FAIL read_ar_timeout addr=%h", a); end
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < TMO) begin @(negedge clk); n++; end
    if (!rvalid) begin n_cmp++; n_err++; $display("FAIL read_r_timeout addr=%h", a); end
    d = rdata; resp = rresp; stable = 1'b1;
    for (int k = 0; k < rdelay; k++) begin
      @(negedge clk);
      if (!rvalid || rdata !== d) stable = 1'b0;
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic ib, h;
    logic [1:0] r;
    axi_write(a, d, 4'hF, 0, 4'h0, ib, h, r);
  endtask

  task automatic pulse(input logic [3:0] m);
    @(negedge clk); intr = intr | m;
    @(negedge clk); intr = intr & ~m;
  endtask

  task automatic test_reset();
    logic [4:0] addrs [6] = '{A_GIE, A_IER, A_ISR, A_IAR, A_IPR, A_IMR};
    logic [31:0] d, e;
    logic [1:0] r;
    logic st;
    rst = 1'b1; intr = '0; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    wdata = '0; wstrb = '0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin n_err++;
      $display("FAIL reset_handshake got %b expected 00000", {awready, wready, bvalid, arready, rvalid}); end
    n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h expected 0", rdata); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b expected 0", irq); end
    n_cmp++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL reset_irq_active_low got %b expected 1", irq_n); end
    for (int i = 0; i < 6; i++) exp_q.push_back(32'h0);
    for (int i = 0; i < 6; i++) begin
      axi_read(addrs[i], 0, d, r, st);
      e = exp_q.pop_front();
      n_cmp++; if (d !== e || r !== 2'b00) begin n_err++;
        $display("FAIL reset_reg addr=%h got %h/%b expected %h/00", addrs[i], d, r, e); end
    end
  endtask

  task automatic test_single_source();
    logic [31:0] d, e;
    logic [1:0] r;
    logic st;
    wr(A_GIE, 32'h1);
    wr(A_IER, 32'h1);
    @(negedge clk); intr[0] = 1'b1;
    @(negedge clk); intr[0] = 1'b0;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_early got %b expected 0", irq); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_latency got %b expected 1", irq); end
    n_cmp++; if (irq_n !== 1'b0) begin n_err++; $display("FAIL irq_active_low got %b expected 0", irq_n); end
    exp_q.push_back(32'h1);
    axi_read(A_IPR, 0, d, r, st);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_err++; $display("FAIL ipr_set got %h expected %h", d, e); end
    wr(A_IAR, 32'h1);
    exp_q.push_back(32'h0);
    axi_read(A_IPR, 0, d, r, st);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_err++; $display("FAIL ipr_acked got %h expected %h", d, e); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_acked got %b expected 0", irq); end
  endtask

  task automatic test_level();
    logic [31:0] d, e;
    logic [1:0] r;
    logic st;
    wr(A_IER, 32'hF);
    @(negedge clk); intr[2] = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL level_irq got %b expected 1", irq); end
    wr(A_IAR, 32'h4);
    exp_q.push_back(32'h4);
    axi_read(A_ISR, 0, d, r, st);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_err++; $display("FAIL level_reset got %h expected %h", d, e); end
    @(negedge clk); intr[2] = 1'b0;
    wr(A_IAR, 32'h4);
    exp_q.push_back(32'h0);
    axi_read(A_ISR, 0, d, r, st);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_err++; $display("FAIL level_clear got %h expected %h", d, e); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL level_irq_clear got %b expected 0", irq); end
  endtask

  task automatic test_strobe();
    logic [31:0] d, e;
    logic [1:0] r;
    logic st, ib, h;
    logic [3:0] strbs [3] = '{4'b0000, 4'b0001, 4'b1110};
    logic [31:0] datas [3] = '{32'hFF, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] exps [3] = '{32'h0, 32'hF, 32'hF};
    for (int i = 0; i < 3; i++) begin
      axi_write(A_IMR, datas[i], strbs[i], 0, 4'h0, ib, h, r);
      exp_q.push_back(exps[i]);
      axi_read(A_IMR, 0, d, r, st);
      e = exp_q.pop_front();
      n_cmp++; if (d !== e) begin n_err++; $display("FAIL strobe_imr step=%0d got %h expected %h", i, d, e); end
    end
  endtask

  task automatic test_edge_collision();
    logic [31:0] d, e;
    logic [1:0] r;
    logic st, ib, h;
    pulse(4'h2);
    repeat (2) @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL edge_irq got %b expected 1", irq); end
    axi_write(A_IAR, 32'h2, 4'hF, 0, 4'h2, ib, h, r);
    n_cmp++; if (ib !== 1'b1 || irq !== 1'b1) begin n_err++;
      $display("FAIL collide_irq got %b%b expected 11", ib, irq); end
    exp_q.push_back(32'h2);
    axi_read(A_ISR, 0, d, r, st);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_err++; $display("FAIL collide_isr got %h expected %h", d, e); end
    wr(A_IAR, 32'h2);
    exp_q.push_back(32'h0);
    axi_read(A_ISR, 0, d, r, st);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_err++; $display("FAIL edge_held_ack got %h expected %h", d, e); end
    wr(A_IMR, 32'h0);
    exp_q.push_back(32'h2);
    axi_read(A_ISR, 0, d, r, st);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_err++; $display("FAIL edge_to_level got %h expected %h", d, e); end
    @(negedge clk); intr = '0;
    wr(A_IAR, 32'hF);
    exp_q.push_back(32'h0);
    axi_read(A_ISR, 0, d, r, st);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_err++; $display("FAIL edge_cleanup got %h expected %h", d, e); end
  endtask

  task automatic test_ier_mask();
    logic [31:0] d, e;
    logic [1:0] r;
    logic st, ib, h;
    wr(A_IER, 32'h2);
    pulse(4'h1);
    repeat (2) @(negedge clk);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);
    axi_read(A_ISR, 0, d, r, st);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_err++; $display("FAIL mask_isr got %h expected %h", d, e); end
    axi_read(A_IPR, 0, d, r, st);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_err++; $display("FAIL mask_ipr got %h expected %h", d, e); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL mask_irq got %b expected 0", irq); end
    axi_write(A_IER, 32'h3, 4'hF, 0, 4'h0, ib, h, r);
    n_cmp++; if (ib !== 1'b0 || irq !== 1'b1) begin n_err++;
      $display("FAIL unmask_irq got %b%b expected 01", ib, irq); end
    axi_write(A_GIE, 32'h0, 4'hF, 0, 4'h0, ib, h, r);
    n_cmp++; if (ib !== 1'b1 || irq !== 1'b0) begin n_err++;
      $display("FAIL gie_off_irq got %b%b expected 10", ib, irq); end
    exp_q.push_back(32'h1);
    axi_read(A_ISR, 0, d, r, st);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_err++; $display("FAIL gie_off_isr got %h expected %h", d, e); end
    wr(A_IAR, 32'hF);
  endtask

  task automatic test_handshake();
    logic [31:0] d, e;
    logic [1:0] r;
    logic st, ib, h;
    axi_write(A_IER, 32'hA, 4'hF, 5, 4'h0, ib, h, r);
    n_cmp++; if (h !== 1'b1 || r !== 2'b00) begin n_err++;
      $display("FAIL bvalid_hold got %b/%b expected 1/00", h, r); end
    exp_q.push_back(32'hA);
    axi_read(A_IER, 5, d, r, st);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e || st !== 1'b1 || r !== 2'b00) begin n_err++;
      $display("FAIL rvalid_hold got %h/%b/%b expected %h/1/00", d, st, r, e); end
    wr(5'h18, 32'hFFFF);
    wr(A_ISR, 32'hF);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hA);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    axi_read(5'h1C, 0, d, r, st);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e || r !== 2'b00) begin n_err++; $display("FAIL unmapped_read got %h/%b expected %h/00", d, r, e); end
    axi_read(A_IER, 0, d, r, st);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_err++; $display("FAIL unmapped_write got %h expected %h", d, e); end
    axi_read(A_ISR, 0, d, r, st);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_err++; $display("FAIL isr_readonly got %h expected %h", d, e); end
    axi_read(A_IMR, 0, d, r, st);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_err++; $display("FAIL imr_untouched got %h expected %h", d, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, e;
    logic [1:0] r, rw;
    logic st, ib, h;
    exp_q.push_back(32'h0);
    fork
      axi_write(A_IER, 32'h5, 4'hF, 0, 4'h0, ib, h, rw);
      axi_read(A_GIE, 0, d, r, st);
    join
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_err++; $display("FAIL concurrent_read got %h expected %h", d, e); end
    exp_q.push_back(32'h5);
    axi_read(A_IER, 0, d, r, st);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_err++; $display("FAIL concurrent_write got %h expected %h", d, e); end
  endtask

  task automatic test_reset_mid();
    logic [4:0] addrs [4] = '{A_GIE, A_IER, A_ISR, A_IMR};
    logic [31:0] d, e;
    logic [1:0] r;
    logic st;
    int n;
    wr(A_GIE, 32'h1);
    wr(A_IER, 32'hF);
    pulse(4'h8);
    repeat (2) @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL pre_reset_irq got %b expected 1", irq); end
    @(negedge clk);
    awaddr = A_IER; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!bvalid && n < TMO) begin @(negedge clk); n++; end
    n_cmp++; if (bvalid !== 1'b1) begin n_err++; $display("FAIL open_write_bvalid got %b expected 1", bvalid); end
    awvalid = 1'b0; wvalid = 1'b0; rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bvalid !== 1'b0 || irq !== 1'b0 || irq_n !== 1'b1) begin n_err++;
      $display("FAIL mid_reset got b=%b irq=%b irq_n=%b expected 0 0 1", bvalid, irq, irq_n); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      axi_read(addrs[i], 0, d, r, st);
      e = exp_q.pop_front();
      n_cmp++; if (d !== e) begin n_err++; $display("FAIL post_reset addr=%h got %h expected %h", addrs[i], d, e); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_source();
    test_level();
    test_strobe();
    test_edge_collision();
    test_ier_mask();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
